ddr_tx_scheduler: RTL and testbench

Sequencer that feeds the two-bit-per-clock DDR output flop. It accepts parallel sample words over a valid/ready handshake and shifts each word out MSB-first as rising/falling-edge bit pairs on `d_rise`/`d_fall`. Between bursts it parks the line at a fixed idle level, and it flags underruns. It sits between the waveform sample source (FIFO or pattern engine) and the DDR output flop of the wave generator's output pin.

---
 rtl/ddr_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_ddr_tx_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_tx_scheduler.sv
// DDR transmit sequencer: shifts parallel words out MSB-first as rise/fall bit pairs.
// Optional burst preamble is enabled by defining DDR_TX_PREAMBLE_EN.
module ddr_tx_scheduler #(
  parameter int   DATA_W     = 16,
  parameter logic IDLE_VAL   = 1'b0,
  parameter int   PRE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              d_rise,
  output logic              d_fall,
  output logic              busy,
  output logic              underrun
);

  localparam int HALF    = DATA_W / 2;
  // One counter serves both the beat index and the preamble length.
  localparam int CNT_MAX = (HALF > PRE_CYCLES) ? HALF : PRE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HALF - 1);
`ifdef DDR_TX_PREAMBLE_EN
  localparam logic [CNT_W-1:0] LAST_PRE  = CNT_W'(PRE_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sreg;
  logic              r_dRise;
  logic              r_dFall;
  logic              r_underrun;
  logic              w_accept;

  always_comb begin
    s_ready = 1'b0;
    if (!rst) begin
      case (r_state)
`ifdef DDR_TX_PREAMBLE_EN
        IDLE:    s_ready = 1'b0;
        PRE:     s_ready = enable && (r_cnt == LAST_PRE);
`else
        IDLE:    s_ready = enable;
`endif
        SHIFT:   s_ready = enable && (r_cnt == LAST_BEAT);
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = s_valid && s_ready;

  // The MSB pair of a new word goes straight to the outputs at the accept edge,
  // so the shift register holds only the bits still to be sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sreg     <= '0;
      r_dRise    <= IDLE_VAL;
      r_dFall    <= IDLE_VAL;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        IDLE: begin
`ifdef DDR_TX_PREAMBLE_EN
          if (enable && s_valid) begin
            r_state <= PRE;
            r_cnt   <= '0;
            r_dRise <= 1'b1;
            r_dFall <= 1'b0;
          end
`else
          if (w_accept) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_dRise <= s_data[DATA_W-1];
            r_dFall <= s_data[DATA_W-2];
            r_sreg  <= {s_data[DATA_W-3:0], 2'b00};
          end
`endif
        end
`ifdef DDR_TX_PREAMBLE_EN
        PRE: begin
          if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dRise <= IDLE_VAL;
            r_dFall <= IDLE_VAL;
          end else if (r_cnt == LAST_PRE) begin
            if (w_accept) begin
              r_state <= SHIFT;
              r_cnt   <= '0;
              r_dRise <= s_data[DATA_W-1];
              r_dFall <= s_data[DATA_W-2];
              r_sreg  <= {s_data[DATA_W-3:0], 2'b00};
            end else begin
              r_state    <= IDLE;
              r_cnt      <= '0;
              r_dRise    <= IDLE_VAL;
              r_dFall    <= IDLE_VAL;
              r_underrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        SHIFT: begin
          if (r_cnt != LAST_BEAT) begin
            r_dRise <= r_sreg[DATA_W-1];
            r_dFall <= r_sreg[DATA_W-2];
            r_sreg  <= {r_sreg[DATA_W-3:0], 2'b00};
            r_cnt   <= r_cnt + 1'b1;
          end else if (w_accept) begin
            r_cnt   <= '0;
            r_dRise <= s_data[DATA_W-1];
            r_dFall <= s_data[DATA_W-2];
            r_sreg  <= {s_data[DATA_W-3:0], 2'b00};
          end else begin
            // A disabled last beat is a clean stop, not a starved one.
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dRise    <= IDLE_VAL;
            r_dFall    <= IDLE_VAL;
            r_underrun <= enable && !s_valid;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_dRise <= IDLE_VAL;
          r_dFall <= IDLE_VAL;
        end
      endcase
    end
  end

  assign d_rise   = r_dRise;
  assign d_fall   = r_dFall;
  assign underrun = r_underrun;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ddr_tx_scheduler.sv
// Directed self-checking bench for ddr_tx_scheduler (DATA_W=16, IDLE_VAL=0, PRE_CYCLES=4).
module tb_ddr_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        d_rise;
  logic        d_fall;
  logic        busy;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  ddr_tx_scheduler #(
    .DATA_W    (16),
    .IDLE_VAL  (1'b0),
    .PRE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .d_rise  (d_rise),
    .d_fall  (d_fall),
    .busy    (busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; s_valid = 1'b0;
    tick(); tick(); #1;
    checks++; if ({d_rise, d_fall} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pair: got %b expected 00", {d_rise, d_fall}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", s_ready); end
    rst = 1'b0;
    tick(); #1;
`ifndef DDR_TX_PREAMBLE_EN
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 1", s_ready); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    enable = 1'b0;
  endtask

  task automatic test_single();
    logic [15:0] expPairs;
    expPairs = 16'b10_10_01_01_11_00_00_11;
    enable = 1'b1; s_data = 16'hA5C3; s_valid = 1'b1; #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", s_ready); end
    tick(); s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if ({d_rise, d_fall} !== expPairs[15-2*i -: 2]) begin errors++; $display("[TB] FAIL single_pair beat %0d: got %b expected %b", i, {d_rise, d_fall}, expPairs[15-2*i -: 2]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy beat %0d: got %b expected 1", i, busy); end
      tick();
    end
    #1;
    checks++; if ({d_rise, d_fall} !== 2'b00) begin errors++; $display("[TB] FAIL single_idle: got %b expected 00", {d_rise, d_fall}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL single_underrun: got %b expected 1", underrun); end
    tick(); #1;
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL single_underrun_pulse: got %b expected 0", underrun); end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1; s_data = 16'hFFFF; s_valid = 1'b1; #1;
    tick(); s_data = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if ({d_rise, d_fall} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_first_pair beat %0d: got %b expected 11", i, {d_rise, d_fall}); end
      checks++; if (s_ready !== (i == 7)) begin errors++; $display("[TB] FAIL b2b_ready beat %0d: got %b expected %b", i, s_ready, (i == 7)); end
      tick();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if ({d_rise, d_fall} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_second_pair beat %0d: got %b expected 00", i, {d_rise, d_fall}); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy beat %0d: got %b expected 1", i, busy); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_gap beat %0d: got %b expected 0", i, underrun); end
      tick();
    end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL b2b_underrun: got %b expected 1", underrun); end
    tick();
  endtask

  task automatic test_enable_drop();
    enable = 1'b1; s_data = 16'hAAAA; s_valid = 1'b1; #1;
    tick(); s_data = 16'h5555;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) enable = 1'b0;
      #1;
      checks++; if ({d_rise, d_fall} !== 2'b10) begin errors++; $display("[TB] FAIL drop_pair beat %0d: got %b expected 10", i, {d_rise, d_fall}); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL drop_ready beat %0d: got %b expected 0", i, s_ready); end
      tick();
    end
    #1;
    checks++; if ({d_rise, d_fall} !== 2'b00) begin errors++; $display("[TB] FAIL drop_idle: got %b expected 00", {d_rise, d_fall}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL drop_underrun: got %b expected 0", underrun); end
    tick(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_stays_idle: got %b expected 0", busy); end
    s_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    enable = 1'b1; s_data = 16'hA5C3; s_valid = 1'b1; #1;
    tick(); s_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; #1;
    checks++; if ({d_rise, d_fall} !== 2'b11) begin errors++; $display("[TB] FAIL rst_beat4_pair: got %b expected 11", {d_rise, d_fall}); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", s_ready); end
    tick(); #1;
    checks++; if ({d_rise, d_fall} !== 2'b00) begin errors++; $display("[TB] FAIL rst_idle: got %b expected 00", {d_rise, d_fall}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_underrun: got %b expected 0", underrun); end
    rst = 1'b0; s_data = 16'h4000; s_valid = 1'b1; #1;
`ifndef DDR_TX_PREAMBLE_EN
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_fresh_ready: got %b expected 1", s_ready); end
`endif
    tick(); s_valid = 1'b0; #1;
    checks++; if ({d_rise, d_fall} !== 2'b01) begin errors++; $display("[TB] FAIL rst_fresh_pair: got %b expected 01", {d_rise, d_fall}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_fresh_busy: got %b expected 1", busy); end
    for (int i = 0; i < 9; i++) tick();
  endtask

  task automatic test_enable_low();
    enable = 1'b0; s_data = 16'h1234; s_valid = 1'b1; #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL enlow_ready: got %b expected 0", s_ready); end
    tick(); #1;
    checks++; if ({d_rise, d_fall} !== 2'b00) begin errors++; $display("[TB] FAIL enlow_pair: got %b expected 00", {d_rise, d_fall}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL enlow_busy: got %b expected 0", busy); end
    s_valid = 1'b0;
    tick(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL enlow_busy_after: got %b expected 0", busy); end
  endtask

`ifdef DDR_TX_PREAMBLE_EN
  task automatic test_preamble();
    logic [15:0] expPairs;
    expPairs = 16'b10_00_00_00_00_00_00_01;
    enable = 1'b1; s_data = 16'h8001; s_valid = 1'b1; #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL pre_idle_ready: got %b expected 0", s_ready); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({d_rise, d_fall} !== 2'b10) begin errors++; $display("[TB] FAIL pre_pair cycle %0d: got %b expected 10", i, {d_rise, d_fall}); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pre_busy cycle %0d: got %b expected 1", i, busy); end
      checks++; if (s_ready !== (i == 3)) begin errors++; $display("[TB] FAIL pre_ready cycle %0d: got %b expected %b", i, s_ready, (i == 3)); end
      tick();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if ({d_rise, d_fall} !== expPairs[15-2*i -: 2]) begin errors++; $display("[TB] FAIL pre_data beat %0d: got %b expected %b", i, {d_rise, d_fall}, expPairs[15-2*i -: 2]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pre_data_busy beat %0d: got %b expected 1", i, busy); end
      tick();
    end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pre_busy_end: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL pre_underrun: got %b expected 1", underrun); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef DDR_TX_PREAMBLE_EN
    test_preamble();
    test_enable_low();
`else
    test_single();
    test_back_to_back();
    test_enable_drop();
    test_mid_reset();
    test_enable_low();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
